// File: rtl/adder_arbiter.sv
// Two-port round-robin arbiter sharing one 16-bit saturating adder.
// Each requester has at most one operation in flight and a buffered response.
module adder_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic [15:0] rsp0_sum,
  output logic        rsp0_zr,
  output logic        rsp0_neg,
  output logic        rsp0_ov,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  output logic [15:0] rsp1_sum,
  output logic        rsp1_zr,
  output logic        rsp1_neg,
  output logic        rsp1_ov,
  input  logic        rsp1_ready
);

  typedef enum logic [1:0] {IDLE, ISSUED, DONE} state_t;

  state_t      st0, st1, st0_n, st1_n;
  logic        lp;
  logic        grant0, grant1;
  logic        s1_valid, s1_owner;
  logic [15:0] a_q, b_q;
  logic [15:0] raw, add_out;
  logic        add_zr, add_neg, add_ov;

  // Arbitration: lp names the requester granted last, so the other wins a tie.
  always_comb begin
    logic cand0, cand1;
    grant0 = 1'b0;
    grant1 = 1'b0;
    cand0  = req0_valid && (st0 == IDLE);
    cand1  = req1_valid && (st1 == IDLE);
    if (!rst) begin
      if (cand0 && cand1) begin
        grant0 = lp;
        grant1 = !lp;
      end else begin
        grant0 = cand0;
        grant1 = cand1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp0_valid = (st0 == DONE);
  assign rsp1_valid = (st1 == DONE);

  // Shared saturating adder, fed from the stage-1 operand register.
  always_comb begin
    raw     = a_q + b_q;
    add_out = raw;
    add_ov  = 1'b0;
    if (!a_q[15] && !b_q[15] && raw[15]) begin
      add_out = 16'h7FFF;
      add_ov  = 1'b1;
    end else if (a_q[15] && b_q[15] && !raw[15]) begin
      add_out = 16'h8000;
      add_ov  = 1'b1;
    end
    add_zr  = (add_out == '0);
    add_neg = add_out[15];
  end

  always_comb begin
    st0_n = st0;
    st1_n = st1;
    case (st0)
      IDLE:    if (grant0) st0_n = ISSUED;
      ISSUED:  st0_n = DONE;
      DONE:    if (rsp0_ready) st0_n = IDLE;
      default: st0_n = IDLE;
    endcase
    case (st1)
      IDLE:    if (grant1) st1_n = ISSUED;
      ISSUED:  st1_n = DONE;
      DONE:    if (rsp1_ready) st1_n = IDLE;
      default: st1_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st0      <= IDLE;
      st1      <= IDLE;
      lp       <= 1'b1;
      s1_valid <= 1'b0;
      s1_owner <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      rsp0_sum <= '0;
      rsp0_zr  <= 1'b0;
      rsp0_neg <= 1'b0;
      rsp0_ov  <= 1'b0;
      rsp1_sum <= '0;
      rsp1_zr  <= 1'b0;
      rsp1_neg <= 1'b0;
      rsp1_ov  <= 1'b0;
    end else begin
      st0      <= st0_n;
      st1      <= st1_n;
      s1_valid <= grant0 || grant1;
      s1_owner <= grant1;
      if (grant0) begin
        lp  <= 1'b0;
        a_q <= req0_a;
        b_q <= req0_b;
      end else if (grant1) begin
        lp  <= 1'b1;
        a_q <= req1_a;
        b_q <= req1_b;
      end else begin
        a_q <= '0;
        b_q <= '0;
      end
      // Buffers load only at the end of ISSUED and then hold through backpressure.
      if (s1_valid && !s1_owner) begin
        rsp0_sum <= add_out;
        rsp0_zr  <= add_zr;
        rsp0_neg <= add_neg;
        rsp0_ov  <= add_ov;
      end
      if (s1_valid && s1_owner) begin
        rsp1_sum <= add_out;
        rsp1_zr  <= add_zr;
        rsp1_neg <= add_neg;
        rsp1_ov  <= add_ov;
      end
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter.
module tb_adder_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [15:0] rsp0_sum, rsp1_sum;
  logic        rsp0_zr, rsp0_neg, rsp0_ov, rsp1_zr, rsp1_neg, rsp1_ov;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_sum(rsp0_sum), .rsp0_zr(rsp0_zr),
    .rsp0_neg(rsp0_neg), .rsp0_ov(rsp0_ov), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_sum(rsp1_sum), .rsp1_zr(rsp1_zr),
    .rsp1_neg(rsp1_neg), .rsp1_ov(rsp1_ov), .rsp1_ready(rsp1_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 16'h0003; req0_b = 16'h0004;
    req1_a = 16'h0001; req1_b = 16'h0001;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      checks++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got rdy/vld %b expected 0000", i,
                 {req0_ready, req1_ready, rsp0_valid, rsp1_valid});
      end
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL reset_first_grant: got %b expected 10", {req0_ready, req1_ready});
    end
    checks++;
    if ({rsp0_sum, rsp0_zr, rsp0_neg, rsp0_ov, rsp1_sum, rsp1_zr, rsp1_neg, rsp1_ov} !== '0) begin
      errors++;
      $display("FAIL reset_rsp_data: got %h/%h expected 0000/0000", rsp0_sum, rsp1_sum);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_basic();
    tick();
    req0_valid = 1'b1; req0_a = 16'h0003; req0_b = 16'h0004; rsp0_ready = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready: got %b expected 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    #1;
    checks++;
    if (rsp0_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_c1_valid: got %b expected 0", rsp0_valid);
    end
    tick();
    checks++;
    if ({rsp0_valid, rsp0_sum, rsp0_zr, rsp0_neg, rsp0_ov} !== {1'b1, 16'h0007, 3'b000}) begin
      errors++;
      $display("FAIL basic_rsp: got v%b %h z%b n%b o%b expected v1 0007 z0 n0 o0",
               rsp0_valid, rsp0_sum, rsp0_zr, rsp0_neg, rsp0_ov);
    end
    tick();
    checks++;
    if (rsp0_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_c3_valid: got %b expected 0", rsp0_valid);
    end
  endtask

  typedef struct {
    logic [15:0] a, b, s;
    logic [2:0]  f;   // {zr, neg, ov}
  } vec_t;

  task automatic test_flags();
    vec_t v[5];
    v[0] = '{16'h7FFF, 16'h0001, 16'h7FFF, 3'b001};
    v[1] = '{16'h8000, 16'hFFFF, 16'h8000, 3'b011};
    v[2] = '{16'h0005, 16'hFFFB, 16'h0000, 3'b100};
    v[3] = '{16'hFFFE, 16'h0001, 16'hFFFF, 3'b010};
    v[4] = '{16'h1234, 16'h1111, 16'h2345, 3'b000};
    rsp1_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      req1_valid = 1'b1; req1_a = v[i].a; req1_b = v[i].b;
      #1;
      checks++;
      if (req1_ready !== 1'b1) begin
        errors++;
        $display("FAIL flags_ready[%0d]: got %b expected 1", i, req1_ready);
      end
      tick();
      req1_valid = 1'b0;
      tick();
      checks++;
      if ({rsp1_valid, rsp1_sum, rsp1_zr, rsp1_neg, rsp1_ov} !== {1'b1, v[i].s, v[i].f}) begin
        errors++;
        $display("FAIL flags_rsp[%0d]: got v%b %h zno=%b%b%b expected v1 %h zno=%b", i,
                 rsp1_valid, rsp1_sum, rsp1_zr, rsp1_neg, rsp1_ov, v[i].s, v[i].f);
      end
    end
  endtask

  task automatic test_contention();
    logic [15:0] e0, e1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      req0_valid = 1'b1; req0_a = 16'(k * 16);  req0_b = 16'd1;
      req1_valid = 1'b1; req1_a = 16'(k * 256); req1_b = 16'd2;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== {k % 3 == 0, k % 3 == 1}) begin
        errors++;
        $display("FAIL cont_grant[%0d]: got %b expected %b", k,
                 {req0_ready, req1_ready}, {k % 3 == 0, k % 3 == 1});
      end
      e0 = 16'((k - 2) * 16 + 1);
      e1 = 16'((k - 2) * 256 + 2);
      if (k % 3 == 2) begin
        checks++;
        if ({rsp0_valid, rsp0_sum, rsp1_valid} !== {1'b1, e0, 1'b0}) begin
          errors++;
          $display("FAIL cont_rsp0[%0d]: got v%b %h v1=%b expected v1 %h v1=0", k,
                   rsp0_valid, rsp0_sum, rsp1_valid, e0);
        end
      end else if (k % 3 == 0 && k >= 3) begin
        checks++;
        if ({rsp1_valid, rsp1_sum, rsp0_valid} !== {1'b1, e1, 1'b0}) begin
          errors++;
          $display("FAIL cont_rsp1[%0d]: got v%b %h v0=%b expected v1 %h v0=0", k,
                   rsp1_valid, rsp1_sum, rsp0_valid, e1);
        end
      end else begin
        checks++;
        if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
          errors++;
          $display("FAIL cont_idle[%0d]: got %b expected 00", k, {rsp0_valid, rsp1_valid});
        end
      end
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    checks++;
    if ({rsp1_valid, rsp1_sum} !== {1'b1, 16'd2562}) begin
      errors++;
      $display("FAIL cont_drain: got v%b %h expected v1 0a02", rsp1_valid, rsp1_sum);
    end
  endtask

  task automatic test_back_to_back_backpressure();
    tick();
    req0_valid = 1'b1; req0_a = 16'h0100; req0_b = 16'h0023; rsp0_ready = 1'b0;
    rsp1_ready = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_issue0: got %b expected 1", req0_ready);
    end
    tick();
    req1_valid = 1'b1; req1_a = 16'h0010; req1_b = 16'h0020;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_issue1: got %b expected 01", {req0_ready, req1_ready});
    end
    tick();
    req1_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      #1;
      checks++;
      if ({rsp0_valid, rsp0_sum, rsp0_zr, rsp0_neg, rsp0_ov, req0_ready} !==
          {1'b1, 16'h0123, 3'b000, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v%b %h zno=%b%b%b rdy%b expected v1 0123 zno=000 rdy0",
                 i, rsp0_valid, rsp0_sum, rsp0_zr, rsp0_neg, rsp0_ov, req0_ready);
      end
      if (i == 1) begin
        checks++;
        if ({rsp1_valid, rsp1_sum} !== {1'b1, 16'h0030}) begin
          errors++;
          $display("FAIL bp_req1_rsp: got v%b %h expected v1 0030", rsp1_valid, rsp1_sum);
        end
      end
    end
    tick();
    rsp0_ready = 1'b1; req0_valid = 1'b0;
    #1;
    checks++;
    if (rsp0_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_valid: got %b expected 1", rsp0_valid);
    end
    tick();
    checks++;
    if (rsp0_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_cleared: got %b expected 0", rsp0_valid);
    end
  endtask

  task automatic test_reset_mid();
    tick();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h0002; req1_b = 16'h0002;
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0001;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_issue0: got %b expected 1", req0_ready);
    end
    tick();
    req0_valid = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if ({rsp1_valid, rsp0_valid, req0_ready, req1_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL mid_pre_reset: got %b expected 1000",
               {rsp1_valid, rsp0_valid, req0_ready, req1_ready});
    end
    tick();
    rst = 1'b0; req0_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp1_sum} !== {2'b00, 16'h0000}) begin
      errors++;
      $display("FAIL mid_after_reset: got v%b%b %h expected v00 0000",
               rsp0_valid, rsp1_valid, rsp1_sum);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
        errors++;
        $display("FAIL mid_no_late[%0d]: got %b expected 00", i, {rsp0_valid, rsp1_valid});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flags();
    test_contention();
    test_back_to_back_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
